rr_client_requester: RTL and testbench
======================================

// Module: rr_client_requester
// PURPOSE
//  Client-side counterpart of the round robin arbiter: per-client job queues drive request[] and consume grant[].
//  Queues jobs pushed by local producers (one credit counter per client).
//  Holds request[i] high, stable, until granted.
//  Retires one job per accepted grant and flags protocol violations by the arbiter.
// PARAMETERS
//  CLIENTS       32    number of clients; must match arbiter CLIENTS
//  DEPTH         8     max pending jobs per client (>=1)
//  STARVE_LIMIT  64    cycles request may wait before starve flag (STARVE_CHECK only)
// PORTS
//  clock        in   1        clock
//  reset        in   1        reset, synchronous, active-high
//  push         in   CLIENTS  push[i]=1: enqueue one job for client i
//  push_ready   out  CLIENTS  push_ready[i]=1: client i count < DEPTH
//  request      out  CLIENTS  to arbiter; request[i] = (count[i] != 0)
//  grant        in   CLIENTS  from arbiter
//  stall        in   1        from arbiter; grant ignored while stall=1
//  served       out  CLIENTS  1-cycle pulse: job of client i retired this cycle
//  overflow     out  1        sticky: push to a full client
//  grant_err    out  1        sticky: illegal grant observed
//  starve       out  CLIENTS  STARVE_CHECK only; else tied 0
// BEHAVIOUR
//  - Reset: all counts 0. request=0, served=0, overflow=0, grant_err=0, starve=0. push_ready=all 1s.
//  - count[i] is CNT_W=$clog2(DEPTH+1) bits, registered. request is combinational from count (no extra latency).
//  - Accepted grant: acc[i] = grant[i] & !stall & request[i] & $onehot(grant).
//  - Next count:
//      +1 if push[i] & push_ready[i]
//      -1 if acc[i]
//      unchanged if both or neither.
//  - served[i] is registered: equals acc[i] of the previous cycle (1-cycle latency).
//  - Push when count==DEPTH: push dropped, overflow set. Simultaneous grant still decrements.
//  - Stability rule: count decrements only on acc.
//      Request 1 -> 0 only in the cycle after a grant of the last job.
//      Never deasserted without a grant.
//  - grant_err set when !stall and either:
//      grant not onehot0, or
//      grant[i]=1 with request[i]=0.
//    No count changes that cycle. Never underflows.
//  - stall=1: grants ignored and not checked; counts change by push only.
//  - Sticky flags clear only on reset. Reset mid-operation discards all pending jobs.
// CONFIGURATION
//  RR_CLIENT_STARVE_CHECK_EN defined:
//    - per-client wait counter, width $clog2(STARVE_LIMIT+1).
//    - Increments while request[i] & !acc[i]; cleared on acc[i] or request[i]=0.
//    - Saturates at STARVE_LIMIT; starve[i]=1 while counter==STARVE_LIMIT (registered).
//  Undefined: no wait counters; starve = '0.
// STRUCTURE
//  rr_client_pkg:
//    - typedef cnt_t (CNT_W bits)
//    - function onehot0_f
//    - localparam default CLIENTS/DEPTH
//  Sub-module rr_client_lane:
//    - one client: count, push_ready, request, served, optional wait counter.
//    - Instantiated CLIENTS times by generate.
//  Top holds the onehot check, acc logic and sticky flags.
// TESTING
//  - Reset then push[3] x3 over 3 cycles, no grant -> request[3]=1 held, count 3, push_ready[3]=1.
//  - grant=1<<3 for 3 cycles, stall=0 -> served[3] pulses x3 (1 cycle late), request[3]=0 after the 3rd.
//  - Push+grant same cycle on client 5 with count 2 -> count stays 2, served[5]=1 next cycle.
//  - 9 pushes to client 0 (DEPTH 8) -> push_ready[0]=0 after 8, overflow=1, count=8.
//  - grant=0x3 -> grant_err=1, no served pulse.
//  - grant[7] with request[7]=0 -> grant_err=1.
//  - grant[2] during stall=1 -> ignored, count unchanged.
//  - STARVE_CHECK_EN, STARVE_LIMIT=4: request[1] held 4 cycles with no grant -> starve[1]=1; grant -> starve[1]=0.

Source files
------------

// File: rtl/rr_client_pkg.sv
// rr_client_pkg: shared types, defaults and helpers for the round robin client requester.
package rr_client_pkg;
  localparam int CLIENTS_DEF = 32;
  localparam int DEPTH_DEF = 8;
  localparam int CNT_W = $clog2(DEPTH_DEF + 1);
  localparam int MAX_CLIENTS = 256;
  typedef logic [CNT_W-1:0] cnt_t;
  function automatic logic onehot0_f(input logic [MAX_CLIENTS-1:0] v);
    return (v & (v - 1'b1)) == '0;
  endfunction
endpackage

// File: rtl/rr_client_if.sv
// rr_client_if: producer/arbiter-facing bundle of the client requester.
interface rr_client_if #(parameter int CLIENTS = 32);
  logic [CLIENTS-1:0] push;
  logic [CLIENTS-1:0] push_ready;
  logic [CLIENTS-1:0] request;
  logic [CLIENTS-1:0] grant;
  logic               stall;
  logic [CLIENTS-1:0] served;
  logic               overflow;
  logic               grant_err;
  logic [CLIENTS-1:0] starve;
  modport master (
    output push, grant, stall,
    input  push_ready, request, served, overflow, grant_err, starve
  );
  modport slave (
    input  push, grant, stall,
    output push_ready, request, served, overflow, grant_err, starve
  );
endinterface

// File: rtl/rr_client_lane.sv
// rr_client_lane: one client's job counter, request and served pulse, plus optional wait counter
// (RR_CLIENT_STARVE_CHECK_EN).
module rr_client_lane #(
  parameter int DEPTH = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic acc,
  output logic push_ready,
  output logic request,
  output logic served,
  output logic push_drop,
  output logic starve
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  logic [CNT_W-1:0] count_q, count_d;
  logic served_q, served_d;
  always_comb begin
    push_ready = count_q != CNT_W'(DEPTH);
    request = count_q != '0;
    push_drop = push & !push_ready;
    count_d = count_q + CNT_W'(push & push_ready) - CNT_W'(acc);
    served_d = acc;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      served_q <= 1'b0;
    end else begin
      count_q <= count_d;
      served_q <= served_d;
    end
  end
  assign served = served_q;
`ifdef RR_CLIENT_STARVE_CHECK_EN
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  // Counts cycles spent requesting without acceptance, saturating at the limit.
  always_comb begin
    wait_d = (!request || acc) ? '0
           : (wait_q == WAIT_W'(STARVE_LIMIT)) ? wait_q : wait_q + WAIT_W'(1);
  end
  always_ff @(posedge clock) begin
    if (reset) wait_q <= '0;
    else wait_q <= wait_d;
  end
  assign starve = wait_q == WAIT_W'(STARVE_LIMIT);
`else
  assign starve = 1'b0;
`endif
endmodule

// File: rtl/rr_client_requester.sv
// rr_client_requester: per-client job queues driving arbiter requests, with grant checking.
// Optional starvation flags via RR_CLIENT_STARVE_CHECK_EN.
module rr_client_requester
  import rr_client_pkg::*;
#(
  parameter int CLIENTS = CLIENTS_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int STARVE_LIMIT = 64
) (
  input logic      clock,
  input logic      reset,
  rr_client_if.slave bus
);
  logic [CLIENTS-1:0] push_ready, request, served, push_drop, starve, acc;
  logic overflow_q, overflow_d, grant_err_q, grant_err_d;
  logic grant_oh0, bad;
  // A grant retires a job only when it is the single grant of a non-stalled cycle.
  always_comb begin
    grant_oh0 = onehot0_f(MAX_CLIENTS'(bus.grant));
    bad = !bus.stall && (!grant_oh0 || |(bus.grant & ~request));
    acc = (!bus.stall && grant_oh0) ? bus.grant & request : '0;
    overflow_d = overflow_q | |push_drop;
    grant_err_d = grant_err_q | bad;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q <= 1'b0;
      grant_err_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      grant_err_q <= grant_err_d;
    end
  end
  for (genvar i = 0; i < CLIENTS; i++) begin : g_lane
    rr_client_lane #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) u_lane (
      .clock      (clock),
      .reset      (reset),
      .push       (bus.push[i]),
      .acc        (acc[i]),
      .push_ready (push_ready[i]),
      .request    (request[i]),
      .served     (served[i]),
      .push_drop  (push_drop[i]),
      .starve     (starve[i])
    );
  end
  assign bus.push_ready = push_ready;
  assign bus.request = request;
  assign bus.served = served;
  assign bus.starve = starve;
  assign bus.overflow = overflow_q;
  assign bus.grant_err = grant_err_q;
endmodule

// File: tb/tb_rr_client_requester.sv
// tb_rr_client_requester: directed vector table plus hand sequences for rr_client_requester.
module tb_rr_client_requester;
  localparam logic [31:0] ALL = 32'hFFFF_FFFF;
  typedef struct {
    logic [31:0] push;
    logic [31:0] grant;
    logic        stall;
    logic [31:0] req;
    logic [31:0] pr;
    logic [31:0] srv;
    logic        ovf;
    logic        gerr;
  } vec_t;
  logic clock, reset;
  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  rr_client_if #(.CLIENTS(32)) bus();
  rr_client_requester #(.CLIENTS(32), .DEPTH(8), .STARVE_LIMIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  function automatic logic [31:0] on(input int n);
    return 32'h1 << n;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic add(input logic [31:0] p, input logic [31:0] g, input logic s,
                     input logic [31:0] r, input logic [31:0] pr, input logic [31:0] sv,
                     input logic o, input logic e);
    vec_t v;
    v.push = p; v.grant = g; v.stall = s; v.req = r; v.pr = pr; v.srv = sv; v.ovf = o; v.gerr = e;
    vecs.push_back(v);
  endtask
  task automatic drive(input logic [31:0] p, input logic [31:0] g, input logic s);
    bus.push = p;
    bus.grant = g;
    bus.stall = s;
  endtask
  initial begin
    repeat (3) add(on(3), 0, 0, on(3), ALL, 0, 0, 0);
    add(0, 0, 0, on(3), ALL, 0, 0, 0);
    repeat (2) add(0, on(3), 0, on(3), ALL, on(3), 0, 0);
    add(0, on(3), 0, 0, ALL, on(3), 0, 0);
    add(0, 0, 0, 0, ALL, 0, 0, 0);
    repeat (2) add(on(5), 0, 0, on(5), ALL, 0, 0, 0);
    add(on(5), on(5), 0, on(5), ALL, on(5), 0, 0);
    add(0, on(5), 0, on(5), ALL, on(5), 0, 0);
    add(0, on(5), 0, 0, ALL, on(5), 0, 0);
    add(on(2), 0, 0, on(2), ALL, 0, 0, 0);
    add(0, on(2), 1, on(2), ALL, 0, 0, 0);
    add(0, on(2), 0, 0, ALL, on(2), 0, 0);
    add(0, 32'h3, 1, 0, ALL, 0, 0, 0);
    repeat (7) add(on(0), 0, 0, on(0), ALL, 0, 0, 0);
    add(on(0), 0, 0, on(0), ~on(0), 0, 0, 0);
    add(on(0), 0, 0, on(0), ~on(0), 0, 1, 0);
    add(on(0), on(0), 0, on(0), ALL, on(0), 1, 0);
    repeat (6) add(0, on(0), 0, on(0), ALL, on(0), 1, 0);
    add(0, on(0), 0, 0, ALL, on(0), 1, 0);
    add(32'h3, 0, 0, 32'h3, ALL, 0, 1, 0);
    add(0, 32'h3, 0, 32'h3, ALL, 0, 1, 1);
    add(0, 0, 0, 32'h3, ALL, 0, 1, 1);
    add(0, 32'h1, 0, 32'h2, ALL, 32'h1, 1, 1);
    add(0, 32'h2, 0, 0, ALL, 32'h2, 1, 1);
    drive(0, 0, 0);
    reset = 1'b1;
    repeat (2) step();
    chk("rst_request", bus.request, 0);
    chk("rst_push_ready", bus.push_ready, ALL);
    chk("rst_served", bus.served, 0);
    chk("rst_flags", {30'd0, bus.overflow, bus.grant_err}, 0);
    chk("rst_starve", bus.starve, 0);
    reset = 1'b0;
    foreach (vecs[k]) begin
      drive(vecs[k].push, vecs[k].grant, vecs[k].stall);
      step();
      chk($sformatf("v%0d_request", k), bus.request, vecs[k].req);
      chk($sformatf("v%0d_push_ready", k), bus.push_ready, vecs[k].pr);
      chk($sformatf("v%0d_served", k), bus.served, vecs[k].srv);
      chk($sformatf("v%0d_overflow", k), 32'(bus.overflow), 32'(vecs[k].ovf));
      chk($sformatf("v%0d_grant_err", k), 32'(bus.grant_err), 32'(vecs[k].gerr));
    end
    drive(on(4), 0, 0);
    repeat (2) step();
    chk("pre_reset_request", bus.request, on(4));
    drive(0, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_request", bus.request, 0);
    chk("midrst_flags", {30'd0, bus.overflow, bus.grant_err}, 0);
    drive(0, on(7), 0);
    step();
    chk("idle_grant_err", 32'(bus.grant_err), 1);
    chk("idle_grant_served", bus.served, 0);
    drive(0, 0, 0);
    step();
    chk("idle_grant_sticky", 32'(bus.grant_err), 1);
    chk("idle_grant_request", bus.request, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(on(1), 0, 0);
    step();
    drive(0, 0, 0);
    repeat (3) step();
    chk("starve_early", bus.starve, 0);
    step();
`ifdef RR_CLIENT_STARVE_CHECK_EN
    chk("starve_set", bus.starve, on(1));
`else
    chk("starve_off", bus.starve, 0);
`endif
    repeat (2) step();
`ifdef RR_CLIENT_STARVE_CHECK_EN
    chk("starve_hold", bus.starve, on(1));
`else
    chk("starve_off_hold", bus.starve, 0);
`endif
    drive(0, on(1), 0);
    step();
    drive(0, 0, 0);
    chk("starve_clear", bus.starve, 0);
    chk("starve_served", bus.served, on(1));
    chk("starve_request", bus.request, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
